// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bus of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        gnt;
    logic [NUM_CH-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     err;

    modport slave (
        input  req, we, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        output gnt, rvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output req, we, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        input  gnt, rvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_CH requesters, holding each
// decision until memory accepts it and routing in-order responses back via an ID FIFO.
module mem_port_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4,
    parameter bit RR_EN       = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int DW = $clog2(OUTST_DEPTH);

    typedef enum logic {ARB, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] rr_ptr, held_ch, arb_ch, base, win;
    logic          arb_any, any, full, mem_req, push, pop, err;
    logic [CW-1:0] fifo [OUTST_DEPTH];
    logic [DW-1:0] wr_ptr, rd_ptr;
    logic [DW:0]   count;

    assign base = RR_EN ? rr_ptr : '0;

    // Descending scan so the last hit is the closest to base in wrap order.
    always_comb begin
        arb_ch  = '0;
        arb_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.req[CW'((int'(base) + i) % NUM_CH)]) begin
                arb_ch  = CW'((int'(base) + i) % NUM_CH);
                arb_any = 1'b1;
            end
        end
    end

    assign win     = (state == HOLD) ? held_ch : arb_ch;
    assign any     = (state == HOLD) ? bus.req[held_ch] : arb_any;
    assign full    = count == (DW+1)'(OUTST_DEPTH);
    assign mem_req = rst_n & any & ~full;
    assign push    = mem_req & bus.mem_gnt;
    assign pop     = rst_n & bus.mem_rvalid & (count != '0);

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = rst_n & bus.we[win];
    assign bus.mem_addr  = rst_n ? bus.addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign bus.mem_wdata = rst_n ? bus.wdata[int'(win)*DATA_W +: DATA_W] : '0;
    assign bus.gnt       = push ? NUM_CH'(1) << win : '0;
    assign bus.rvalid    = pop ? NUM_CH'(1) << fifo[rd_ptr] : '0;
    assign bus.rdata     = rst_n ? bus.mem_rdata : '0;
    assign bus.err       = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            rr_ptr  <= '0;
            held_ch <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DW+1)'(push) - (DW+1)'(pop);
            if (push && RR_EN) rr_ptr <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
            // A held request blocked only by a full FIFO stays held.
            state <= push ? ARB : mem_req ? HOLD : (state == HOLD && bus.req[held_ch]) ? HOLD : ARB;
            if (state == ARB) held_ch <= arb_ch;
            if ((state == HOLD && !bus.req[held_ch]) || (bus.mem_rvalid && count == '0)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= win;
    end
endmodule
